udatapath_pipe: RTL and testbench

//  Parametrised two-stage datapath: N-entry register file, dual read buses A/B, write bus C.

---
 rtl/udatapath_pkg.sv | 25 ++
 rtl/udatapath_alu.sv | 59 +++++
 rtl/udatapath_pipe.sv | 190 +++++++++++++++++++
 tb/tb_udatapath_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udatapath_pkg.sv
// udatapath_pkg: shared definitions for the two-stage micro datapath.
// Holds the ALU opcode encodings, the bit positions of {N,Z,V,C} inside the
// 4-bit flags word, and the default ALU opcode width.
package udatapath_pkg;

   localparam int ALU_SEL_W_DEF = 4;

   // ALU opcodes; any other code yields a zero result
   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_XOR   = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_PASSA = 4'd5;
   localparam logic [3:0] OP_PASSB = 4'd6;
   localparam logic [3:0] OP_SLL1  = 4'd7;
   localparam logic [3:0] OP_SRL1  = 4'd8;

   // Bit positions inside the flags word {N,Z,V,C}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/udatapath_alu.sv
// udatapath_alu: purely combinational ALU.
// Ports:
//   a, b   W-bit operands
//   op     SEL_W-bit opcode (udatapath_pkg OP_*)
//   res    W-bit result, wraps on overflow
//   n,z    result MSB / result equals zero
//   v,c    signed overflow and carry (ADD) or not-borrow (SUB); zero otherwise
module udatapath_alu
   import udatapath_pkg::*;
#(
   parameter int W     = 32,
   parameter int SEL_W = ALU_SEL_W_DEF
) (
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [SEL_W-1:0] op,
   output logic [W-1:0]     res,
   output logic             n,
   output logic             z,
   output logic             v,
   output logic             c
);

   logic [W:0] sum_s;
   logic [W:0] diff_s;

   // Opcode decode and flag generation; SUB is formed as A + ~B + 1 so the
   // carry out is the inverted borrow.
   always_comb begin
      sum_s  = {1'b0, a} + {1'b0, b};
      diff_s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
      res    = {W{1'b0}};
      v      = 1'b0;
      c      = 1'b0;
      case (op)
         SEL_W'(OP_AND):   res = a & b;
         SEL_W'(OP_OR):    res = a | b;
         SEL_W'(OP_XOR):   res = a ^ b;
         SEL_W'(OP_ADD): begin
            res = sum_s[W-1:0];
            c   = sum_s[W];
            v   = (a[W-1] == b[W-1]) && (sum_s[W-1] != a[W-1]);
         end
         SEL_W'(OP_SUB): begin
            res = diff_s[W-1:0];
            c   = diff_s[W];
            v   = (a[W-1] != b[W-1]) && (diff_s[W-1] != a[W-1]);
         end
         SEL_W'(OP_PASSA): res = a;
         SEL_W'(OP_PASSB): res = b;
         SEL_W'(OP_SLL1):  res = {a[W-2:0], 1'b0};
         SEL_W'(OP_SRL1):  res = {1'b0, a[W-1:1]};
         default:          res = {W{1'b0}};
      endcase
      n = res[W-1];
      z = (res == {W{1'b0}});
   end

endmodule

// File: rtl/udatapath_pipe.sv
// udatapath_pipe: two-stage datapath (E: read/bypass/ALU, W: write-back)
// around an N-entry register file with a shared external write port.
// Ports:
//   udatapath_pipe_CLOCK_50      clock, rising edge
//   udatapath_pipe_RESET_InHigh  synchronous reset, active high
//   uop_valid / uop_ready        micro-op handshake (ready whenever not in reset)
//   sel_*_src, ctl_*             per-port address source: control field or IR field
//   alu_op, wr_en, flag_we       operation, write-back enable, flags update enable
//   ext_we/ext_addr/ext_data     external (memory load) write request
//   ext_ready                    external write accepted when no W write is pending
//   bus_a, bus_b                 operands after bypass (combinational)
//   ir_out                       stored contents of register IR_INDEX
//   result, result_valid         W-stage result and valid
//   flags                        {N,Z,V,C}, registered
module udatapath_pipe
   import udatapath_pkg::*;
#(
   parameter int DATAWIDTH_BUS = 32,
   parameter int NUM_REGS      = 16,
   parameter int IR_INDEX      = 15,
   parameter int IR_A_LSB      = 14,
   parameter int IR_B_LSB      = 9,
   parameter int IR_C_LSB      = 4,
   parameter int ZERO_REG      = 1,
   parameter int ALU_SEL_W     = ALU_SEL_W_DEF,
   localparam int ADDR_W       = $clog2(NUM_REGS),
   localparam int W            = DATAWIDTH_BUS
) (
   input  logic                 udatapath_pipe_CLOCK_50,
   input  logic                 udatapath_pipe_RESET_InHigh,
   input  logic                 uop_valid,
   output logic                 uop_ready,
   input  logic                 sel_a_src,
   input  logic [ADDR_W-1:0]    ctl_a,
   input  logic                 sel_b_src,
   input  logic [ADDR_W-1:0]    ctl_b,
   input  logic                 sel_c_src,
   input  logic [ADDR_W-1:0]    ctl_c,
   input  logic [ALU_SEL_W-1:0] alu_op,
   input  logic                 wr_en,
   input  logic                 flag_we,
   input  logic                 ext_we,
   input  logic [ADDR_W-1:0]    ext_addr,
   input  logic [W-1:0]         ext_data,
   output logic                 ext_ready,
   output logic [W-1:0]         bus_a,
   output logic [W-1:0]         bus_b,
   output logic [W-1:0]         ir_out,
   output logic [W-1:0]         result,
   output logic                 result_valid,
   output logic [3:0]           flags
);

   localparam logic [ADDR_W-1:0] IR_ADDR = ADDR_W'(IR_INDEX);

   logic [W-1:0]      regFile_r [NUM_REGS];
   logic              wValid_r;
   logic              wWr_r;
   logic [ADDR_W-1:0] wDest_r;
   logic [W-1:0]      result_r;
   logic [3:0]        flags_r;

   logic              wPending_s;
   logic              irHit_s;
   logic [ADDR_W-1:0] irFieldA_s;
   logic [ADDR_W-1:0] irFieldB_s;
   logic [ADDR_W-1:0] irFieldC_s;
   logic [ADDR_W-1:0] addrA_s;
   logic [ADDR_W-1:0] addrB_s;
   logic [ADDR_W-1:0] addrC_s;
   logic [W-1:0]      busA_s;
   logic [W-1:0]      busB_s;
   logic              uopAccept_s;
   logic [W-1:0]      aluRes_s;
   logic              aluN_s;
   logic              aluZ_s;
   logic              aluV_s;
   logic              aluC_s;

   // True when addr names the hard-wired zero register
   function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
   endfunction

   assign wPending_s  = wValid_r && wWr_r;
   assign uop_ready   = !udatapath_pipe_RESET_InHigh;
   assign uopAccept_s = uop_valid && uop_ready;
   assign ext_ready   = !wPending_s;

   // Address selection and operand read with W-stage bypass. The IR fields
   // see a pending IR write too, so an address loaded into IR by the previous
   // uop is usable immediately. External writes are never bypassed.
   always_comb begin
      irHit_s = wPending_s && (wDest_r == IR_ADDR) && !isZeroReg(IR_ADDR);
      if (irHit_s) begin
         irFieldA_s = result_r[IR_A_LSB +: ADDR_W];
         irFieldB_s = result_r[IR_B_LSB +: ADDR_W];
         irFieldC_s = result_r[IR_C_LSB +: ADDR_W];
      end else begin
         irFieldA_s = regFile_r[IR_ADDR][IR_A_LSB +: ADDR_W];
         irFieldB_s = regFile_r[IR_ADDR][IR_B_LSB +: ADDR_W];
         irFieldC_s = regFile_r[IR_ADDR][IR_C_LSB +: ADDR_W];
      end
      addrA_s = sel_a_src ? irFieldA_s : ctl_a;
      addrB_s = sel_b_src ? irFieldB_s : ctl_b;
      addrC_s = sel_c_src ? irFieldC_s : ctl_c;

      if (isZeroReg(addrA_s)) begin
         busA_s = {W{1'b0}};
      end else if (wPending_s && (wDest_r == addrA_s)) begin
         busA_s = result_r;
      end else begin
         busA_s = regFile_r[addrA_s];
      end

      if (isZeroReg(addrB_s)) begin
         busB_s = {W{1'b0}};
      end else if (wPending_s && (wDest_r == addrB_s)) begin
         busB_s = result_r;
      end else begin
         busB_s = regFile_r[addrB_s];
      end
   end

   udatapath_alu #(
      .W     (W),
      .SEL_W (ALU_SEL_W)
   ) u_alu (
      .a   (busA_s),
      .b   (busB_s),
      .op  (alu_op),
      .res (aluRes_s),
      .n   (aluN_s),
      .z   (aluZ_s),
      .v   (aluV_s),
      .c   (aluC_s)
   );

   // Register file write port: W-stage write-back has the port; an external
   // write only lands when none is pending. Zero-register writes are dropped.
   always_ff @(posedge udatapath_pipe_CLOCK_50) begin
      if (udatapath_pipe_RESET_InHigh) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regFile_r[i] <= {W{1'b0}};
         end
      end else if (wPending_s) begin
         if (!isZeroReg(wDest_r)) begin
            regFile_r[wDest_r] <= result_r;
         end
      end else if (ext_we) begin
         if (!isZeroReg(ext_addr)) begin
            regFile_r[ext_addr] <= ext_data;
         end
      end
   end

   // E-to-W pipeline register and flags; result holds when no uop retires
   always_ff @(posedge udatapath_pipe_CLOCK_50) begin
      if (udatapath_pipe_RESET_InHigh) begin
         wValid_r <= 1'b0;
         wWr_r    <= 1'b0;
         wDest_r  <= {ADDR_W{1'b0}};
         result_r <= {W{1'b0}};
         flags_r  <= 4'b0000;
      end else begin
         if (uopAccept_s) begin
            wValid_r <= 1'b1;
            wWr_r    <= wr_en;
            wDest_r  <= addrC_s;
            result_r <= aluRes_s;
         end else begin
            wValid_r <= 1'b0;
         end
         if (uopAccept_s && flag_we) begin
            flags_r[FLAG_N] <= aluN_s;
            flags_r[FLAG_Z] <= aluZ_s;
            flags_r[FLAG_V] <= aluV_s;
            flags_r[FLAG_C] <= aluC_s;
         end
      end
   end

   assign bus_a        = busA_s;
   assign bus_b        = busB_s;
   assign ir_out       = regFile_r[IR_ADDR];
   assign result       = result_r;
   assign result_valid = wValid_r;
   assign flags        = flags_r;

endmodule

// File: tb/tb_udatapath_pipe.sv
// tb_udatapath_pipe: directed self-checking bench for udatapath_pipe with the
// default parameters (32-bit, 16 registers, IR in r15, zero register on).
module tb_udatapath_pipe;
   import udatapath_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        uopValid;
   logic        uopReady;
   logic        selA, selB, selC;
   logic [3:0]  ctlA, ctlB, ctlC;
   logic [3:0]  aluOp;
   logic        wrEn, flagWe;
   logic        extWe;
   logic [3:0]  extAddr;
   logic [31:0] extData;
   logic        extReady;
   logic [31:0] busA, busB, irOut, result;
   logic        resultValid;
   logic [3:0]  flags;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   udatapath_pipe dut (
      .udatapath_pipe_CLOCK_50     (clk),
      .udatapath_pipe_RESET_InHigh (rst),
      .uop_valid    (uopValid),
      .uop_ready    (uopReady),
      .sel_a_src    (selA),
      .ctl_a        (ctlA),
      .sel_b_src    (selB),
      .ctl_b        (ctlB),
      .sel_c_src    (selC),
      .ctl_c        (ctlC),
      .alu_op       (aluOp),
      .wr_en        (wrEn),
      .flag_we      (flagWe),
      .ext_we       (extWe),
      .ext_addr     (extAddr),
      .ext_data     (extData),
      .ext_ready    (extReady),
      .bus_a        (busA),
      .bus_b        (busB),
      .ir_out       (irOut),
      .result       (result),
      .result_valid (resultValid),
      .flags        (flags)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      uopValid = 1'b0; selA = 1'b0; selB = 1'b0; selC = 1'b0;
      ctlA = 4'd0; ctlB = 4'd0; ctlC = 4'd0; aluOp = 4'd0;
      wrEn = 1'b0; flagWe = 1'b0; extWe = 1'b0; extAddr = 4'd0; extData = 32'd0;
   endtask

   task automatic setUop(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic wr, input logic fw);
      idle();
      uopValid = 1'b1; aluOp = op; ctlA = a; ctlB = b; ctlC = c; wrEn = wr; flagWe = fw;
   endtask

   task automatic extWrite(input logic [3:0] addr, input logic [31:0] data);
      idle();
      extWe = 1'b1; extAddr = addr; extData = data;
      tick();
      extWe = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      total++; if (uopReady !== 1'b0) begin bad++; $display("FAIL reset_uop_ready: got %b expected 0", uopReady); end
      tick();
      rst = 1'b0;
      #1;
      total++; if (uopReady !== 1'b1) begin bad++; $display("FAIL uop_ready: got %b expected 1", uopReady); end
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b expected 0", resultValid); end
      total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b expected 0000", flags); end
      total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h expected 0", result); end
      total++; if (extReady !== 1'b1) begin bad++; $display("FAIL reset_ext_ready: got %b expected 1", extReady); end
      total++; if (irOut !== 32'd0) begin bad++; $display("FAIL reset_ir: got %h expected 0", irOut); end
      for (int i = 0; i < 16; i++) begin
         ctlA = 4'(i); ctlB = 4'(15 - i);
         #1;
         total++; if (busA !== 32'd0) begin bad++; $display("FAIL reset_bus_a r%0d: got %h expected 0", i, busA); end
         total++; if (busB !== 32'd0) begin bad++; $display("FAIL reset_bus_b r%0d: got %h expected 0", 15 - i, busB); end
      end
   endtask

   task automatic test_add();
      extWrite(4'd1, 32'd5);
      extWrite(4'd2, 32'd7);
      setUop(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
      #1;
      total++; if (busA !== 32'd5) begin bad++; $display("FAIL add_bus_a: got %h expected 5", busA); end
      total++; if (busB !== 32'd7) begin bad++; $display("FAIL add_bus_b: got %h expected 7", busB); end
      tick();
      idle();
      total++; if (result !== 32'd12) begin bad++; $display("FAIL add_result: got %h expected c", result); end
      total++; if (resultValid !== 1'b1) begin bad++; $display("FAIL add_rv: got %b expected 1", resultValid); end
      total++; if (flags !== 4'b0000) begin bad++; $display("FAIL add_flags: got %b expected 0000", flags); end
      ctlA = 4'd3;
      #1;
      total++; if (busA !== 32'd12) begin bad++; $display("FAIL add_bypass_r3: got %h expected c", busA); end
      tick();
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL add_rv_drop: got %b expected 0", resultValid); end
      total++; if (result !== 32'd12) begin bad++; $display("FAIL add_result_hold: got %h expected c", result); end
      total++; if (busA !== 32'd12) begin bad++; $display("FAIL add_r3_written: got %h expected c", busA); end
   endtask

   task automatic test_back_to_back();
      extWrite(4'd3, 32'd99);
      setUop(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
      tick();
      setUop(OP_SUB, 4'd3, 4'd1, 4'd4, 1'b1, 1'b1);
      #1;
      total++; if (busA !== 32'd12) begin bad++; $display("FAIL b2b_bypass_a: got %h expected c", busA); end
      total++; if (busB !== 32'd5) begin bad++; $display("FAIL b2b_bus_b: got %h expected 5", busB); end
      total++; if (extReady !== 1'b0) begin bad++; $display("FAIL b2b_ext_ready: got %b expected 0", extReady); end
      tick();
      idle();
      total++; if (result !== 32'd7) begin bad++; $display("FAIL b2b_result: got %h expected 7", result); end
      total++; if (flags !== 4'b0001) begin bad++; $display("FAIL b2b_flags: got %b expected 0001", flags); end
      tick();
      ctlA = 4'd4; ctlB = 4'd3;
      #1;
      total++; if (busA !== 32'd7) begin bad++; $display("FAIL b2b_r4: got %h expected 7", busA); end
      total++; if (busB !== 32'd12) begin bad++; $display("FAIL b2b_r3: got %h expected c", busB); end
   endtask

   task automatic test_flags_ops();
      logic [3:0]  opT   [0:10];
      logic [3:0]  aT    [0:10];
      logic [3:0]  bT    [0:10];
      logic        fwT   [0:10];
      logic [31:0] resT  [0:10];
      logic [3:0]  flgT  [0:10];
      extWrite(4'd5, 32'h7FFF_FFFF);
      extWrite(4'd6, 32'h0000_0001);
      setUop(OP_ADD, 4'd5, 4'd6, 4'd7, 1'b1, 1'b1);
      tick();
      setUop(OP_SUB, 4'd0, 4'd0, 4'd8, 1'b1, 1'b1);
      total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL ovf_result: got %h expected 80000000", result); end
      total++; if (flags !== 4'b1010) begin bad++; $display("FAIL ovf_flags: got %b expected 1010", flags); end
      tick();
      idle();
      total++; if (result !== 32'd0) begin bad++; $display("FAIL sub00_result: got %h expected 0", result); end
      total++; if (flags !== 4'b0101) begin bad++; $display("FAIL sub00_flags: got %b expected 0101", flags); end
      tick();
      // r5 = 7FFFFFFF, r6 = 1, r7 = 80000000; no write-back in this table
      opT  = '{OP_AND, OP_XOR, OP_OR, OP_PASSA, OP_PASSB, OP_SLL1, OP_SRL1, OP_SUB, OP_SUB, 4'd9, OP_ADD};
      aT   = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd7, 4'd5, 4'd6};
      bT   = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
      fwT  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      resT = '{32'h0000_0001, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001,
               32'hFFFF_FFFE, 32'h3FFF_FFFF, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'h0000_0000,
               32'h0000_0002};
      flgT = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0001,
               4'b0011, 4'b0100, 4'b0100};
      for (int i = 0; i < 11; i++) begin
         setUop(opT[i], aT[i], bT[i], 4'd9, 1'b0, fwT[i]);
         tick();
         total++; if (result !== resT[i]) begin bad++; $display("FAIL op%0d_result: got %h expected %h", i, result, resT[i]); end
         total++; if (flags !== flgT[i]) begin bad++; $display("FAIL op%0d_flags: got %b expected %b", i, flags, flgT[i]); end
      end
      idle();
      tick();
   endtask

   task automatic test_ext_ready();
      setUop(OP_ADD, 4'd1, 4'd2, 4'd10, 1'b1, 1'b0);
      tick();
      idle();
      extWe = 1'b1; extAddr = 4'd9; extData = 32'h55; ctlA = 4'd10; ctlB = 4'd9;
      #1;
      total++; if (extReady !== 1'b0) begin bad++; $display("FAIL ext_blocked: got %b expected 0", extReady); end
      tick();
      total++; if (extReady !== 1'b1) begin bad++; $display("FAIL ext_unblocked: got %b expected 1", extReady); end
      total++; if (busB !== 32'd0) begin bad++; $display("FAIL ext_not_early: got %h expected 0", busB); end
      total++; if (busA !== 32'd12) begin bad++; $display("FAIL ext_w_won: got %h expected c", busA); end
      tick();
      extWe = 1'b0;
      #1;
      total++; if (busB !== 32'h55) begin bad++; $display("FAIL ext_landed: got %h expected 55", busB); end
      // same-cycle external write is not bypassed
      extWe = 1'b1; extAddr = 4'd11; extData = 32'h77; ctlA = 4'd11;
      #1;
      total++; if (busA !== 32'd0) begin bad++; $display("FAIL ext_no_bypass: got %h expected 0", busA); end
      tick();
      extWe = 1'b0;
      #1;
      total++; if (busA !== 32'h77) begin bad++; $display("FAIL ext_r11: got %h expected 77", busA); end
      // zero register ignores both write paths
      extWrite(4'd0, 32'hDEAD);
      ctlA = 4'd0;
      #1;
      total++; if (busA !== 32'd0) begin bad++; $display("FAIL r0_ext: got %h expected 0", busA); end
      setUop(OP_ADD, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0);
      tick();
      idle();
      #1;
      total++; if (busA !== 32'd0) begin bad++; $display("FAIL r0_bypass: got %h expected 0", busA); end
      tick();
      total++; if (busA !== 32'd0) begin bad++; $display("FAIL r0_uop: got %h expected 0", busA); end
      // W valid without write leaves the port free
      setUop(OP_PASSA, 4'd1, 4'd0, 4'd12, 1'b0, 1'b0);
      tick();
      idle();
      #1;
      total++; if (extReady !== 1'b1) begin bad++; $display("FAIL ext_ready_nowr: got %b expected 1", extReady); end
   endtask

   task automatic test_ir();
      extWrite(4'd15, 32'h0000_82B0);
      #1;
      total++; if (irOut !== 32'h0000_82B0) begin bad++; $display("FAIL ir_load: got %h expected 82b0", irOut); end
      setUop(OP_ADD, 4'd5, 4'd6, 4'd7, 1'b1, 1'b0);
      selA = 1'b1; selB = 1'b1; selC = 1'b1;
      #1;
      total++; if (busA !== 32'd7) begin bad++; $display("FAIL ir_field_a: got %h expected 7", busA); end
      total++; if (busB !== 32'd5) begin bad++; $display("FAIL ir_field_b: got %h expected 5", busB); end
      tick();
      idle();
      total++; if (result !== 32'd12) begin bad++; $display("FAIL ir_result: got %h expected c", result); end
      tick();
      ctlA = 4'd11; ctlB = 4'd7;
      #1;
      total++; if (busA !== 32'd12) begin bad++; $display("FAIL ir_field_c: got %h expected c", busA); end
      total++; if (busB !== 32'h8000_0000) begin bad++; $display("FAIL ir_ctl_c_unused: got %h expected 80000000", busB); end
      // pending IR write feeds the address fields of the next uop
      extWrite(4'd12, 32'h0001_8000);
      setUop(OP_PASSA, 4'd12, 4'd0, 4'd15, 1'b1, 1'b0);
      tick();
      setUop(OP_PASSA, 4'd2, 4'd0, 4'd9, 1'b0, 1'b0);
      selA = 1'b1;
      #1;
      total++; if (busA !== 32'd1) begin bad++; $display("FAIL ir_bypass: got %h expected 1", busA); end
      total++; if (irOut !== 32'h0000_82B0) begin bad++; $display("FAIL ir_out_old: got %h expected 82b0", irOut); end
      tick();
      idle();
      total++; if (result !== 32'd1) begin bad++; $display("FAIL ir_bypass_result: got %h expected 1", result); end
      total++; if (irOut !== 32'h0001_8000) begin bad++; $display("FAIL ir_out_new: got %h expected 18000", irOut); end
   endtask

   task automatic test_reset_midop();
      setUop(OP_ADD, 4'd1, 4'd2, 4'd13, 1'b1, 1'b1);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ctlA = 4'd13; ctlB = 4'd1;
      #1;
      total++; if (busA !== 32'd0) begin bad++; $display("FAIL rst_pending_r13: got %h expected 0", busA); end
      total++; if (busB !== 32'd0) begin bad++; $display("FAIL rst_r1: got %h expected 0", busB); end
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL rst_rv: got %b expected 0", resultValid); end
      total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_result: got %h expected 0", result); end
      total++; if (flags !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %b expected 0000", flags); end
      total++; if (irOut !== 32'd0) begin bad++; $display("FAIL rst_ir: got %h expected 0", irOut); end
      tick();
      total++; if (busA !== 32'd0) begin bad++; $display("FAIL rst_r13_after: got %h expected 0", busA); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_add();
      test_back_to_back();
      test_flags_ops();
      test_ext_ready();
      test_ir();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
